// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-street light sequencer with minimum-green, fixed-yellow timing
// and parade override that parks B on green while i_M is high.
module traffic_light_ctrl #(
    parameter int YELLOW_CYC = 5,
    parameter int MIN_GREEN  = 3,
    parameter int CNT_W      = $clog2((YELLOW_CYC > MIN_GREEN) ? YELLOW_CYC : MIN_GREEN) + 1
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_TA,
    input  logic       i_TB,
    input  logic       i_M,
    output logic [1:0] o_LA,
    output logic [1:0] o_LB,
    output logic [1:0] o_state
);
    typedef enum logic [1:0] {S_AG = 2'd0, S_AY = 2'd1, S_BG = 2'd2, S_BY = 2'd3} state_t;
    state_t state, nxt;
    logic [CNT_W-1:0] cnt;
    logic min_ok, y_done;
    assign min_ok = cnt >= CNT_W'(MIN_GREEN - 1);
    assign y_done = cnt == CNT_W'(YELLOW_CYC - 1);
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= S_AG;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= (nxt != state) ? '0 : (&cnt ? cnt : cnt + 1'b1);
        end
    end
    always_comb begin
        nxt = state;
        case (state)
            S_AG:    nxt = (min_ok && (!i_TA || i_M)) ? S_AY : S_AG;
            S_AY:    nxt = y_done ? S_BG : S_AY;
            S_BG:    nxt = (min_ok && !i_M && !i_TB) ? S_BY : S_BG;
            S_BY:    nxt = y_done ? S_AG : S_BY;
            default: nxt = S_AG;
        endcase
    end
    // Lamps decode only from the registered state, so no input reaches an output combinationally.
    always_comb begin
        o_LA    = 2'b10;
        o_LB    = 2'b10;
        o_state = state;
        case (state)
            S_AG:    begin o_LA = 2'b00; o_LB = 2'b10; end
            S_AY:    begin o_LA = 2'b01; o_LB = 2'b10; end
            S_BG:    begin o_LA = 2'b10; o_LB = 2'b00; end
            S_BY:    begin o_LA = 2'b10; o_LB = 2'b01; end
            default: begin o_LA = 2'b10; o_LB = 2'b10; end
        endcase
    end
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: directed sequence checks of lamp/state timing, parade and reset cases.
module tb_traffic_light_ctrl;
    logic       i_clk = 1'b0;
    logic       i_rstn, i_TA, i_TB, i_M;
    logic [1:0] o_LA, o_LB, o_state;
    int n_chk = 0;
    int n_pass = 0;

    traffic_light_ctrl dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_TA(i_TA), .i_TB(i_TB), .i_M(i_M),
        .o_LA(o_LA), .o_LB(o_LB), .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got={LA,LB,state}=%b expected=%b at %0t", tag, got, exp, $time);
    endtask

    // {LA, LB, state} expected for each state code
    function automatic logic [5:0] lamps(input logic [1:0] s);
        case (s)
            2'd0:    lamps = 6'b00_10_00;
            2'd1:    lamps = 6'b01_10_01;
            2'd2:    lamps = 6'b10_00_10;
            default: lamps = 6'b10_01_11;
        endcase
    endfunction

    task automatic run(input string tag, input logic [1:0] s, input int n);
        for (int k = 0; k < n; k++) begin
            chk(tag, {o_LA, o_LB, o_state}, lamps(s));
            @(negedge i_clk);
        end
    endtask

    initial begin
        i_rstn = 1'b1; i_TA = 1'b1; i_TB = 1'b0; i_M = 1'b0;
        #2 i_rstn = 1'b0;
        #1 chk("reset", {o_LA, o_LB, o_state}, 6'b00_10_00);
        @(negedge i_clk);
        i_rstn = 1'b1;
        run("t1_hold_ag", 2'd0, 50);
        i_TA = 1'b0; i_TB = 1'b0;
        @(negedge i_clk);
        run("t2_ay", 2'd1, 5);
        run("t3_bg", 2'd2, 3);
        run("t3_by", 2'd3, 5);
        run("t3_loop_ag", 2'd0, 3);
        run("t3_loop_ay", 2'd1, 5);
        run("t3_loop_bg", 2'd2, 3);
        run("t3_loop_by", 2'd3, 5);
        i_TA = 1'b1; i_M = 1'b1;
        run("t4_ag", 2'd0, 3);
        run("t4_ay", 2'd1, 5);
        run("t4_bg_hold", 2'd2, 100);
        i_M = 1'b0;
        @(negedge i_clk);
        run("t4_by", 2'd3, 2);
        i_M = 1'b1;
        run("t5_by", 2'd3, 3);
        run("t5_ag", 2'd0, 3);
        run("t5_ay", 2'd1, 5);
        run("t5_bg_hold", 2'd2, 20);
        i_M = 1'b0;
        @(negedge i_clk);
        run("t6_by", 2'd3, 5);
        i_TA = 1'b0;
        run("t6_ag", 2'd0, 3);
        run("t6_ay", 2'd1, 2);
        chk("t6_pre_rst", {o_LA, o_LB, o_state}, lamps(2'd1));
        i_rstn = 1'b0;
        #1 chk("t6_async_rst", {o_LA, o_LB, o_state}, 6'b00_10_00);
        @(negedge i_clk);
        i_rstn = 1'b1;
        run("t6_min_green", 2'd0, 3);
        run("t6_ay_after", 2'd1, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
- Light-sequencing FSM for the two-street intersection (Academic Ave = A, Bravado Blvd = B).
- Sits directly downstream of the parade-mode FSM and consumes its mode bit on i_M. Traffic sensors i_TA and i_TB come from the road detectors.
- Drives the A and B lamp codes.
- When i_M=1 (parade), B is forced to green and held there until i_M returns to 0.

Parameters:
- YELLOW_CYC, 5, exact number of clock cycles each yellow phase lasts (>=1).
- MIN_GREEN, 3, minimum number of cycles any green phase lasts before it may be left (>=1).
- CNT_W, $clog2(max(YELLOW_CYC,MIN_GREEN))+1, width of the in-state cycle counter.

Ports:
- i_clk  in  1  clock; all state updates occur on the rising edge.
- i_rstn  in  1  asynchronous, active-low reset.
- i_TA  in  1  traffic present on A (1 = cars waiting/passing).
- i_TB  in  1  traffic present on B.
- i_M  in  1  parade mode from the upstream mode FSM (1 = parade).
- o_LA  out  2  A lamp: 2'b00 green, 2'b01 yellow, 2'b10 red; 2'b11 never driven.
- o_LB  out  2  B lamp, same encoding.
- o_state  out  2  current state code, for debug and verification.

Behaviour:
- Reset and clock:
  - Reset is asynchronous, active-low (i_rstn); clock is i_clk.
  - Reset forces state=S_AG, counter=0, o_LA=00, o_LB=10, o_state=0.
  - Reset asserted mid-phase (including mid-yellow) aborts immediately to S_AG. There is no yellow completion on reset.
- States, registered 2-bit:
  - S_AG=0: LA green, LB red.
  - S_AY=1: LA yellow, LB red.
  - S_BG=2: LA red, LB green.
  - S_BY=3: LA red, LB yellow.
- Outputs: o_LA, o_LB and o_state are Moore outputs, decoded purely from the registered state. They change in the same edge as the state. No input-to-output combinational path.
- Counter:
  - Cleared to 0 on the edge that enters a new state.
  - Otherwise increments each cycle.
  - Saturates at its all-ones value and never wraps.
  - "min_ok" = (cnt >= MIN_GREEN-1).
  - "y_done" = (cnt == YELLOW_CYC-1).
- Transitions, evaluated every cycle:
  - S_AG -> S_AY when min_ok && (!i_TA || i_M); else stay.
  - S_AY -> S_BG when y_done. Sensors and i_M are ignored during yellow.
  - S_BG -> S_BY when min_ok && !i_M && !i_TB; else stay. While i_M=1, S_BG holds indefinitely regardless of i_TB.
  - S_BY -> S_AG when y_done. Inputs are ignored.
- Timing guarantees:
  - Every yellow lasts exactly YELLOW_CYC cycles.
  - Every green lasts at least MIN_GREEN cycles.
  - The minimum full cycle is 2*(MIN_GREEN+YELLOW_CYC) cycles.
- Parade corner cases:
  - i_M rising while in S_BY: yellow completes, then S_AG. After MIN_GREEN cycles, A is released to yellow even if i_TA=1.
  - i_M rising while in S_AY: sequence continues into S_BG and holds there.
  - i_M falling in S_BG: normal i_TB rule resumes the next cycle, still subject to min_ok.
- Simultaneous events:
  - i_TA=0 and i_TB=0 together just alternate phases at minimum timing.
  - Any input change is sampled only at the clock edge. No input synchronizers are included; inputs are already synchronous to i_clk.
- No illegal states are reachable, because all four 2-bit codes are used. The default decode drives red/red (LA=10, LB=10) defensively.

Test Plan:
1. Reset then i_TA=1, i_TB=0, i_M=0 for 50 cycles -> o_LA=00, o_LB=10 throughout; o_state stays 0.
2. From S_AG with cnt saturated, drop i_TA=0 at cycle t -> o_LA=01 from t+1 for exactly 5 cycles. Then o_LA=10, o_LB=00 at t+6.
3. Enter S_BG with i_TB=0, i_M=0 -> B green exactly 3 cycles, yellow 5 cycles, then back to S_AG (LA=00). Total A-to-A loop with i_TA=i_TB=0 is 16 cycles.
4. i_M=1 while in S_AG and i_TA=1 -> leave S_AG after 3 cycles of green, 5 yellow, then S_BG held for 100 cycles despite i_TB=0. De-assert i_M -> S_BY on the next evaluation edge.
5. Assert i_M=1 during S_BY (cycle 2 of yellow) -> yellow still ends after 5 total cycles. Then S_AG for exactly 3 cycles, S_AY, then S_BG held.
6. Pulse i_rstn low for 1 cycle mid-S_AY (cnt=2) -> outputs return asynchronously to LA=00, LB=10, and the counter restarts from 0. After release, a full 3-cycle minimum green is enforced.
